// File: rtl/inst_fetch_way0.sv
// Way-0 instruction fetch stage: one outstanding bus read per request, result
// delivered to decode through a one-entry output slot; jumpFlag_i flushes.
module inst_fetch_way0 #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 64,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 request_i,
    input  logic [AddrWidth-1:0] instAddr_i,
    input  logic                 jumpFlag_i,
    output logic                 ready_o,
    output logic                 dataOk_o,
    output logic                 bus_req_o,
    output logic [AddrWidth-1:0] bus_addr_o,
    input  logic                 bus_gnt_i,
    input  logic                 bus_rvalid_i,
    input  logic [DataWidth-1:0] bus_rdata_i,
    output logic                 inst_valid_o,
    output logic [AddrWidth-1:0] inst_addr_o,
    output logic [DataWidth-1:0] inst_o,
    output logic                 inst_err_o,
    input  logic                 decode_ready_i
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t              state;
    logic [CntWidth-1:0] count;
    logic                timed_out;
    logic                load;
    logic                load_err;

    assign timed_out = (count == CntLast);
    assign ready_o   = (state == IDLE) && (!inst_valid_o || decode_ready_i) && !jumpFlag_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load     = 1'b0;
        load_err = 1'b0;
        if (state == WAIT && !jumpFlag_i) begin
            if (bus_rvalid_i) begin
                load = 1'b1;
            end else if (timed_out) begin
                load     = 1'b1;
                load_err = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bus_req_o  <= 1'b0;
            bus_addr_o <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request_i && ready_o) begin
                        bus_addr_o <= instAddr_i & ~AddrWidth'(7);
                        bus_req_o  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        count     <= '0;
                        state     <= jumpFlag_i ? DROP : WAIT;
                    end else if (jumpFlag_i) begin
                        bus_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    // A response or a timeout ends the read; a jump only diverts it to DROP.
                    if (bus_rvalid_i || timed_out) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (jumpFlag_i) state <= DROP;
                    end
                end
                DROP: begin
                    if (bus_rvalid_i || timed_out) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output slot: a flush beats a reload, a reload beats a drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOk_o     <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_addr_o  <= '0;
            inst_o       <= '0;
            inst_err_o   <= 1'b0;
        end else begin
            dataOk_o <= load;
            if (jumpFlag_i) begin
                inst_valid_o <= 1'b0;
            end else if (load) begin
                inst_valid_o <= 1'b1;
                inst_addr_o  <= bus_addr_o;
                inst_o       <= load_err ? '0 : bus_rdata_i;
                inst_err_o   <= load_err;
            end else if (decode_ready_i) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_way0.sv
// Bench for inst_fetch_way0: directed timing cases plus a randomized fetch stream
// checked against an in-order scoreboard of requested addresses and returned data.
module tb_inst_fetch_way0;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          request_i = 1'b0;
    logic [AW-1:0] instAddr_i = '0;
    logic          jumpFlag_i = 1'b0;
    logic          bus_gnt_i = 1'b0;
    logic          bus_rvalid_i = 1'b0;
    logic [DW-1:0] bus_rdata_i = '0;
    logic          decode_ready_i = 1'b0;
    logic          ready_o, dataOk_o, bus_req_o, inst_valid_o, inst_err_o;
    logic [AW-1:0] bus_addr_o, inst_addr_o;
    logic [DW-1:0] inst_o;

    int n_cmp = 0;
    int n_bad = 0;
    int dok_cnt = 0;

    inst_fetch_way0 #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk(clk), .reset_n(reset_n), .request_i(request_i), .instAddr_i(instAddr_i),
        .jumpFlag_i(jumpFlag_i), .ready_o(ready_o), .dataOk_o(dataOk_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_addr_o(inst_addr_o), .inst_o(inst_o),
        .inst_err_o(inst_err_o), .decode_ready_i(decode_ready_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dataOk_o) dok_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request while idle; returns in the REQ cycle.
    task automatic issue(input string tag, input logic [AW-1:0] a);
        request_i  = 1'b1;
        instAddr_i = a;
        #1;
        check({tag, "_ready"}, ready_o, 1);
        tick();
        request_i = 1'b0;
        check({tag, "_busreq"}, bus_req_o, 1);
        check({tag, "_busaddr"}, bus_addr_o, a & 32'hFFFF_FFF8);
    endtask

    task automatic fetch_ok(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        decode_ready_i = 1'b1;
        issue(tag, a);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = d;
        tick();
        bus_rvalid_i = 1'b0;
        check({tag, "_valid"}, inst_valid_o, 1);
        check({tag, "_data"}, inst_o, d);
        check({tag, "_dok"}, dataOk_o, 1);
        tick();
        check({tag, "_drained"}, inst_valid_o, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int dok0;
        logic [AW-1:0] acc_q[$];
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] exp_d[$];
        int sent, got, cyc, lat, delivered;
        bit granted, waiting, hold_v;
        logic [AW-1:0] hold_a;
        logic [DW-1:0] hold_d;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", inst_valid_o, 0);
        check("rst_dok", dataOk_o, 0);
        check("rst_busreq", bus_req_o, 0);
        check("rst_busaddr", bus_addr_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_err", inst_err_o, 0);
        reset_n = 1'b1;
        #1;
        check("rst_ready", ready_o, 1);

        // Basic fetch, minimum latency
        decode_ready_i = 1'b0;
        issue("basic", 32'h1004);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        check("basic_req_low", bus_req_o, 0);
        check("basic_not_yet", inst_valid_o, 0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h11112222_33334444;
        tick();
        bus_rvalid_i = 1'b0;
        check("basic_valid", inst_valid_o, 1);
        check("basic_inst", inst_o, 64'h11112222_33334444);
        check("basic_addr", inst_addr_o, 32'h1000);
        check("basic_err", inst_err_o, 0);
        check("basic_dok", dataOk_o, 1);

        // Backpressure: slot held, no new request accepted
        request_i  = 1'b1;
        instAddr_i = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ready", ready_o, 0);
            check("bp_valid", inst_valid_o, 1);
            check("bp_inst", inst_o, 64'h11112222_33334444);
            check("bp_busreq", bus_req_o, 0);
            check("bp_dok", dataOk_o, 0);
        end
        decode_ready_i = 1'b1;
        #1;
        check("bp_release_ready", ready_o, 1);
        request_i = 1'b0;
        tick();
        check("bp_drained", inst_valid_o, 0);

        // Flush while waiting for data, orphan rvalid 3 cycles later
        dok0 = dok_cnt;
        issue("flush", 32'h2000);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i  = 1'b0;
        jumpFlag_i = 1'b1;
        tick();
        jumpFlag_i = 1'b0;
        tick();
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus_rvalid_i = 1'b0;
        tick();
        check("flush_valid", inst_valid_o, 0);
        check("flush_dok", dok_cnt - dok0, 0);
        fetch_ok("after_flush", 32'h2008, 64'h0102_0304_0506_0708);

        // Jump coincident with grant, then with rvalid
        dok0 = dok_cnt;
        issue("gj", 32'h4000);
        bus_gnt_i  = 1'b1;
        jumpFlag_i = 1'b1;
        tick();
        bus_gnt_i    = 1'b0;
        jumpFlag_i   = 1'b0;
        bus_rvalid_i = 1'b1;
        tick();
        bus_rvalid_i = 1'b0;
        check("gj_ready", ready_o, 1);
        issue("rj", 32'h5000);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        jumpFlag_i   = 1'b1;
        tick();
        bus_rvalid_i = 1'b0;
        jumpFlag_i   = 1'b0;
        #1;
        check("rj_ready", ready_o, 1);
        tick();
        check("jump_valid", inst_valid_o, 0);
        check("jump_dok", dok_cnt - dok0, 0);

        // Timeout: error entry after TO waiting cycles
        issue("to", 32'h600C);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("to_wait_valid", inst_valid_o, 0);
            tick();
        end
        check("to_valid", inst_valid_o, 1);
        check("to_err", inst_err_o, 1);
        check("to_inst", inst_o, 0);
        check("to_addr", inst_addr_o, 32'h6008);
        check("to_dok", dataOk_o, 1);
        tick();
        check("to_drained", inst_valid_o, 0);

        // Async reset mid-transaction; later orphan rvalid is ignored
        dok0 = dok_cnt;
        issue("rst_mid", 32'h7000);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n = 1'b1;
        bus_rvalid_i = 1'b1;
        tick();
        bus_rvalid_i = 1'b0;
        tick();
        check("rst_mid_valid", inst_valid_o, 0);
        check("rst_mid_dok", dok_cnt - dok0, 0);
        fetch_ok("after_rst", 32'h7010, 64'hAAAA_5555_0F0F_F0F0);

        // Randomized back-to-back stream with in-order scoreboard
        dok0 = dok_cnt;
        sent = 0; got = 0; cyc = 0; lat = 0; delivered = 0;
        granted = 0; waiting = 0; hold_v = 0;
        hold_a = '0; hold_d = '0;
        while (got < 8 && cyc < 500) begin
            tick();
            cyc++;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            request_i    = 1'b0;
            if (hold_v) begin
                check("rnd_hold_valid", inst_valid_o, 1);
                check("rnd_hold_addr", inst_addr_o, hold_a);
                check("rnd_hold_data", inst_o, hold_d);
            end
            if (granted) begin
                waiting = 1;
                lat     = $urandom_range(0, 3);
                granted = 0;
            end
            if (waiting) begin
                if (lat == 0) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = {$urandom, $urandom};
                    exp_a.push_back(acc_q.pop_front());
                    exp_d.push_back(bus_rdata_i);
                    delivered++;
                    waiting = 0;
                end else begin
                    lat--;
                end
            end else if (bus_req_o) begin
                if (acc_q.size() != 0) check("rnd_busaddr", bus_addr_o, acc_q[0]);
                else check("rnd_spurious_req", 1, 0);
                if ($urandom_range(0, 2) != 0) begin
                    bus_gnt_i = 1'b1;
                    granted   = 1;
                end
            end
            decode_ready_i = 1'($urandom_range(0, 1));
            hold_v = inst_valid_o && !decode_ready_i;
            hold_a = inst_addr_o;
            hold_d = inst_o;
            if (inst_valid_o && decode_ready_i) begin
                if (exp_a.size() == 0) begin
                    check("rnd_spurious_out", 1, 0);
                end else begin
                    check("rnd_addr", inst_addr_o, exp_a.pop_front());
                    check("rnd_data", inst_o, exp_d.pop_front());
                    check("rnd_order", inst_addr_o, got * 8);
                    check("rnd_err", inst_err_o, 0);
                end
                got++;
            end
            if (sent < 8) begin
                request_i  = 1'b1;
                instAddr_i = AW'(sent * 8) + AW'($urandom_range(0, 7));
                #1;
                if (ready_o) begin
                    acc_q.push_back(AW'(sent * 8));
                    sent++;
                end
            end
        end
        request_i = 1'b0;
        tick();
        check("rnd_count", got, 8);
        check("rnd_dok", dok_cnt - dok0, delivered);
        check("rnd_left", exp_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
